// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : divider_pkg
//  Description : Shared types and helpers for the sequential restoring divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Each quotient bit is filled with this value on a divide by zero.
    localparam logic ZERO_QUO_FILL = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : divider_pkg
`default_nettype wire

// File: rtl/divider_nbit_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : divider_nbit_seq_if
//  Description : Start/ready request and result bundle of the divider.
//  Revision    : 1.0 - initial release
// ============================================================================
interface divider_nbit_seq_if #(
    parameter int N = 4
) ();

    logic         start;
    logic [N-1:0] dvd;
    logic [N-1:0] dvs;
    logic         ready;
    logic         busy;
    logic         done;
    logic [N-1:0] quo;
    logic [N-1:0] rem;
    logic         div_by_zero;

    modport master (
        output start, dvd, dvs,
        input  ready, busy, done, quo, rem, div_by_zero
    );

    modport slave (
        input  start, dvd, dvs,
        output ready, busy, done, quo, rem, div_by_zero
    );

endinterface : divider_nbit_seq_if
`default_nettype wire

// File: rtl/restoring_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : restoring_div_step
//  Description : One combinational restoring-division iteration (shift, trial
//                subtract, conditional restore).
//  Revision    : 1.0 - initial release
// ============================================================================
module restoring_div_step #(
    parameter int N = 4
) (
    input  wire logic [N:0]   a,
    input  wire logic [N-1:0] q,
    input  wire logic [N-1:0] m,
    output logic      [N:0]   a_next,
    output logic      [N-1:0] q_next
);

    logic [2*N:0] w_aq_shifted;
    logic [N:0]   w_a_shifted;
    logic [N:0]   w_trial;

    assign w_aq_shifted = {a, q} << 1;
    assign w_a_shifted  = w_aq_shifted[2*N:N];

    // N+1 bits keep a shifted partial remainder near 2^N from wrapping.
    assign w_trial = w_a_shifted - {1'b0, m};

    always_comb begin
        a_next = w_a_shifted;
        q_next = w_aq_shifted[N-1:0];
        if (!w_trial[N]) begin
            a_next    = w_trial;
            q_next[0] = 1'b1;
        end
    end

endmodule : restoring_div_step
`default_nettype wire

// File: rtl/divider_nbit_seq.sv
`default_nettype none
// ============================================================================
//  Module      : divider_nbit_seq
//  Description : Sequential unsigned N-bit restoring divider, one quotient bit
//                per clock, with start/ready handshake and done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_nbit_seq
    import divider_pkg::*;
#(
    parameter int N = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    divider_nbit_seq_if.slave  bus
);

    localparam int CW = clog2(N + 1);

    state_t         r_state;
    state_t         w_state_next;

    logic [N:0]     r_a;
    logic [N-1:0]   r_q;
    logic [N-1:0]   r_m;
    logic [CW-1:0]  r_count;
    logic [N-1:0]   r_quo;
    logic [N-1:0]   r_rem;
    logic           r_dbz;

    logic [N:0]     w_a_next;
    logic [N-1:0]   w_q_next;
    logic           w_accept;
    logic           w_last;
    logic           w_ready;
    logic           w_busy;
    logic           w_done;

    assign w_accept = (r_state == ST_IDLE) && bus.start;
    assign w_last   = (r_count == CW'(1));

    restoring_div_step #(
        .N (N)
    ) u_step (
        .a      (r_a),
        .q      (r_q),
        .m      (r_m),
        .a_next (w_a_next),
        .q_next (w_q_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (bus.start) begin
                    w_state_next = (bus.dvs == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_count <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= '0;
                r_q     <= bus.dvd;
                r_m     <= bus.dvs;
                r_count <= CW'(N);
                // A zero divisor skips iteration; its result is latched now so it
                // is already valid in the following DONE cycle.
                if (bus.dvs == '0) begin
                    r_quo <= {N{ZERO_QUO_FILL}};
                    r_rem <= bus.dvd;
                    r_dbz <= 1'b1;
                end else begin
                    r_dbz <= 1'b0;
                end
            end else if (r_state == ST_CALC) begin
                r_a     <= w_a_next;
                r_q     <= w_q_next;
                r_count <= r_count - CW'(1);
                if (w_last) begin
                    r_quo <= w_q_next;
                    r_rem <= w_a_next[N-1:0];
                end
            end
        end
    end

    assign bus.ready       = w_ready;
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.quo         = r_quo;
    assign bus.rem         = r_rem;
    assign bus.div_by_zero = r_dbz;

endmodule : divider_nbit_seq
`default_nettype wire

// File: tb/tb_divider_nbit_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider_nbit_seq
//  Description : Directed and randomised self-checking bench for the divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_nbit_seq;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    divider_nbit_seq_if #(.N(4)) bus4 ();
    divider_nbit_seq_if #(.N(8)) bus8 ();

    divider_nbit_seq #(.N(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    divider_nbit_seq #(.N(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready4(input string tag);
        int n;
        n = 0;
        while (!bus4.ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, " ready wait"}, 32'(bus4.ready), 32'd1);
    endtask

    // Runs one N=4 division; optionally fires a stray 1/1 request mid-CALC.
    task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] eq, input logic [3:0] er, input logic ez,
                        input bit intrude);
        int lat, busy_n, extra_done;
        wait_ready4(tag);
        bus4.start = 1'b1;
        bus4.dvd   = a;
        bus4.dvs   = b;
        tick();
        bus4.start = 1'b0;
        bus4.dvd   = ~a;
        bus4.dvs   = ~b;
        lat    = 1;
        busy_n = 0;
        while (!bus4.done && lat < 20) begin
            if (bus4.busy) busy_n++;
            bus4.start = intrude && (lat == 2 || lat == 3);
            if (bus4.start) begin
                bus4.dvd = 4'd1;
                bus4.dvs = 4'd1;
            end
            tick();
            lat++;
        end
        bus4.start = 1'b0;
        check({tag, " latency"}, 32'(lat), ez ? 32'd1 : 32'd5);
        check({tag, " busy cycles"}, 32'(busy_n), ez ? 32'd0 : 32'd4);
        check({tag, " quo"}, 32'(bus4.quo), 32'(eq));
        check({tag, " rem"}, 32'(bus4.rem), 32'(er));
        check({tag, " dbz"}, 32'(bus4.div_by_zero), 32'(ez));
        tick();
        check({tag, " ready after done"}, 32'(bus4.ready), 32'd1);
        extra_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus4.done) extra_done++;
            tick();
        end
        check({tag, " no extra done"}, 32'(extra_done), 32'd0);
        check({tag, " quo held"}, 32'(bus4.quo), 32'(eq));
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b);
        int lat, pulses;
        logic [15:0] recon;
        n_checks++;
        if (!bus8.ready) begin
            n_errors++;
            $display("FAIL n8 ready: got 0, expected 1 (dvd=%0d dvs=%0d)", a, b);
        end
        bus8.start = 1'b1;
        bus8.dvd   = a;
        bus8.dvs   = b;
        tick();
        bus8.start = 1'b0;
        bus8.dvd   = 8'($urandom);
        bus8.dvs   = 8'($urandom);
        lat = 1;
        while (!bus8.done && lat < 30) begin
            tick();
            lat++;
        end
        pulses = bus8.done ? 1 : 0;
        check("n8 latency", 32'(lat), (b == 8'd0) ? 32'd1 : 32'd9);
        if (b == 8'd0) begin
            check("n8 dbz quo", 32'(bus8.quo), 32'd255);
            check("n8 dbz rem", 32'(bus8.rem), 32'(a));
            check("n8 dbz flag", 32'(bus8.div_by_zero), 32'd1);
        end else begin
            recon = 16'(bus8.quo) * 16'(b) + 16'(bus8.rem);
            check("n8 quo", 32'(bus8.quo), 32'(a / b));
            check("n8 rem", 32'(bus8.rem), 32'(a % b));
            check("n8 invariant", 32'(recon), 32'(a));
            check("n8 rem<dvs", 32'(bus8.rem < b), 32'd1);
            check("n8 dbz flag", 32'(bus8.div_by_zero), 32'd0);
        end
        tick();
        if (bus8.done) pulses++;
        check("n8 done pulses", 32'(pulses), 32'd1);
    endtask

    initial begin
        int dones;
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        bus4.start = 1'b0;
        bus4.dvd   = '0;
        bus4.dvs   = '0;
        bus8.start = 1'b0;
        bus8.dvd   = '0;
        bus8.dvs   = '0;
        tick();
        tick();
        rst = 1'b0;

        check("reset ready", 32'(bus4.ready), 32'd1);
        check("reset busy", 32'(bus4.busy), 32'd0);
        check("reset done", 32'(bus4.done), 32'd0);
        check("reset quo", 32'(bus4.quo), 32'd0);
        check("reset rem", 32'(bus4.rem), 32'd0);
        check("reset dbz", 32'(bus4.div_by_zero), 32'd0);

        run4("13/3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b0);
        run4("3/7", 4'd3, 4'd7, 4'd0, 4'd3, 1'b0, 1'b0);
        run4("15/1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1'b0);
        run4("9/0", 4'd9, 4'd0, 4'd15, 4'd9, 1'b1, 1'b0);
        run4("8/2", 4'd8, 4'd2, 4'd4, 4'd0, 1'b0, 1'b0);
        run4("14/4 intrude", 4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 1'b1);
        run4("15/15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 1'b0);

        // Reset during the second CALC cycle of 11/2.
        wait_ready4("abort");
        bus4.start = 1'b1;
        bus4.dvd   = 4'd11;
        bus4.dvs   = 4'd2;
        tick();
        bus4.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort quo", 32'(bus4.quo), 32'd0);
        check("abort rem", 32'(bus4.rem), 32'd0);
        check("abort dbz", 32'(bus4.div_by_zero), 32'd0);
        check("abort ready", 32'(bus4.ready), 32'd1);
        check("abort busy", 32'(bus4.busy), 32'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus4.done) dones++;
            tick();
        end
        check("abort no done", 32'(dones), 32'd0);
        run4("11/2 after abort", 4'd11, 4'd2, 4'd5, 4'd1, 1'b0, 1'b0);

        run8(8'd255, 8'd16);
        run8(8'd255, 8'd1);
        run8(8'd0, 8'd5);
        run8(8'd200, 8'd255);
        run8(8'd7, 8'd0);
        run8(8'd254, 8'd255);
        for (int i = 0; i < 1994; i++) begin
            run8(8'($urandom), 8'($urandom_range(0, 255)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_divider_nbit_seq
`default_nettype wire
